hazard_track_unit: RTL and testbench

- Hazard-detection and destination-tracking stage for the 5-stage pipelined MIPS CPU.
- Holds the ID/EX, EX/MEM and MEM/WB copies of source and destination register addresses and the RegWrite/MemRead flags.
- Drives the register-address and RegWrite inputs of the Forwarding unit.
- Detects load-use hazards, inserts one bubble, and squashes wrong-path instructions on a taken branch.

---
 rtl/hazard_track_unit.sv | 113 +++++++++++
 tb/tb_hazard_track_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_track_unit.sv
// Hazard detection and destination tracking for the 5-stage MIPS pipeline.
// Define HAZARD_STAT_CNT_EN to add the Stall_cnt/Flush_cnt statistics outputs.
module hazard_track_unit #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] ID_Rs_addr,
    input  logic [ADDR_W-1:0] ID_Rt_addr,
    input  logic [ADDR_W-1:0] ID_Rd_addr,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_Uses_Rt,
    input  logic              Branch_taken,
    output logic              PC_write,
    output logic              IF_ID_write,
    output logic              IF_ID_flush,
    output logic [ADDR_W-1:0] Rs_addr,
    output logic [ADDR_W-1:0] Rt_addr,
    output logic [ADDR_W-1:0] EX_Mem_Rd_addr,
    output logic [ADDR_W-1:0] Mem_WB_Rd_addr,
    output logic              EX_Mem_RegWrite,
    output logic              Mem_WB_RegWrite
`ifdef HAZARD_STAT_CNT_EN
    ,
    output logic [CNT_W-1:0]  Stall_cnt,
    output logic [CNT_W-1:0]  Flush_cnt
`endif
);

    logic [ADDR_W-1:0] id_ex_rs;
    logic [ADDR_W-1:0] id_ex_rt;
    logic [ADDR_W-1:0] id_ex_rd;
    logic              id_ex_regwrite;
    logic              id_ex_memread;
    logic [ADDR_W-1:0] ex_mem_rd;
    logic              ex_mem_regwrite;
    logic [ADDR_W-1:0] mem_wb_rd;
    logic              mem_wb_regwrite;

    logic stall;
    logic flush;

    // A load into $0 never produces a value, so it cannot cause a load-use hazard.
    always_comb begin
        stall = id_ex_memread && (id_ex_rd != '0) &&
                ((id_ex_rd == ID_Rs_addr) || (ID_Uses_Rt && (id_ex_rd == ID_Rt_addr)));
        flush = Branch_taken;
    end

    // A taken branch refetches anyway, so it overrides the stall.
    always_comb begin
        PC_write    = flush || !stall;
        IF_ID_write = flush || !stall;
        IF_ID_flush = flush;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_ex_rs        <= '0;
            id_ex_rt        <= '0;
            id_ex_rd        <= '0;
            id_ex_regwrite  <= 1'b0;
            id_ex_memread   <= 1'b0;
            ex_mem_rd       <= '0;
            ex_mem_regwrite <= 1'b0;
            mem_wb_rd       <= '0;
            mem_wb_regwrite <= 1'b0;
        end else begin
            if (flush || stall) begin
                id_ex_rs       <= '0;
                id_ex_rt       <= '0;
                id_ex_rd       <= '0;
                id_ex_regwrite <= 1'b0;
                id_ex_memread  <= 1'b0;
            end else begin
                id_ex_rs       <= ID_Rs_addr;
                id_ex_rt       <= ID_Rt_addr;
                id_ex_rd       <= ID_Rd_addr;
                id_ex_regwrite <= ID_RegWrite;
                id_ex_memread  <= ID_MemRead;
            end
            // Older instructions are past the branch and always retire.
            ex_mem_rd       <= id_ex_rd;
            ex_mem_regwrite <= id_ex_regwrite;
            mem_wb_rd       <= ex_mem_rd;
            mem_wb_regwrite <= ex_mem_regwrite;
        end
    end

    assign Rs_addr         = id_ex_rs;
    assign Rt_addr         = id_ex_rt;
    assign EX_Mem_Rd_addr  = ex_mem_rd;
    assign EX_Mem_RegWrite = ex_mem_regwrite;
    assign Mem_WB_Rd_addr  = mem_wb_rd;
    assign Mem_WB_RegWrite = mem_wb_regwrite;

`ifdef HAZARD_STAT_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            Stall_cnt <= '0;
            Flush_cnt <= '0;
        end else begin
            if (stall && !flush)
                Stall_cnt <= Stall_cnt + 1'b1;
            if (flush)
                Flush_cnt <= Flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_track_unit.sv
// Self-checking bench for hazard_track_unit: directed scenarios plus random
// traffic checked against an instruction-level pipeline model.
module tb_hazard_track_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_rw, id_mr, id_ut, br;

    logic       PC_write, IF_ID_write, IF_ID_flush;
    logic [4:0] Rs_addr, Rt_addr, EX_Mem_Rd_addr, Mem_WB_Rd_addr;
    logic       EX_Mem_RegWrite, Mem_WB_RegWrite;
`ifdef HAZARD_STAT_CNT_EN
    logic [31:0] Stall_cnt, Flush_cnt;
    int unsigned model_stalls, model_flushes;
`endif

    int total = 0;
    int bad   = 0;

    // One record per instruction; pipe[0] sits in EX, pipe[1] in MEM, pipe[2] in WB.
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } instr_t;
    instr_t pipe [3];

    hazard_track_unit #(.ADDR_W(5), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .ID_Rs_addr(id_rs), .ID_Rt_addr(id_rt), .ID_Rd_addr(id_rd),
        .ID_RegWrite(id_rw), .ID_MemRead(id_mr), .ID_Uses_Rt(id_ut),
        .Branch_taken(br),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .Rs_addr(Rs_addr), .Rt_addr(Rt_addr),
        .EX_Mem_Rd_addr(EX_Mem_Rd_addr), .Mem_WB_Rd_addr(Mem_WB_Rd_addr),
        .EX_Mem_RegWrite(EX_Mem_RegWrite), .Mem_WB_RegWrite(Mem_WB_RegWrite)
`ifdef HAZARD_STAT_CNT_EN
        , .Stall_cnt(Stall_cnt), .Flush_cnt(Flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // The ID instruction must wait if it reads a register a load in EX has not yet fetched.
    function automatic logic model_stall();
        return pipe[0].mr && pipe[0].rd != 5'd0 &&
               (pipe[0].rd == id_rs || (id_ut && pipe[0].rd == id_rt));
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '0;
`ifdef HAZARD_STAT_CNT_EN
        model_stalls  = 0;
        model_flushes = 0;
`endif
    endfunction

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic ut, input logic b);
        @(negedge clk);
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rw = rw; id_mr = mr; id_ut = ut; br = b;
        #1;
    endtask

    // Moves the model across the coming rising edge using the inputs now held.
    task automatic advance();
        instr_t nxt;
        logic   s;
        s = model_stall();
        nxt = (br || s) ? instr_t'(0) : instr_t'({id_rs, id_rt, id_rd, id_rw, id_mr});
`ifdef HAZARD_STAT_CNT_EN
        if (br) model_flushes++;
        else if (s) model_stalls++;
`endif
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nxt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
        id_rw = 1'b0; id_mr = 1'b0; id_ut = 1'b0; br = 1'b0;
        #3;
        total++;
        if ({PC_write, IF_ID_write, IF_ID_flush, Rs_addr, Rt_addr, EX_Mem_Rd_addr,
             EX_Mem_RegWrite, Mem_WB_Rd_addr, Mem_WB_RegWrite} !== {3'b110, 22'd0}) begin
            bad++;
            $display("[TB] FAIL reset_values got pc=%b ifw=%b fl=%b rs=%0d rt=%0d exrd=%0d exrw=%b wbrd=%0d wbrw=%b",
                     PC_write, IF_ID_write, IF_ID_flush, Rs_addr, Rt_addr,
                     EX_Mem_Rd_addr, EX_Mem_RegWrite, Mem_WB_Rd_addr, Mem_WB_RegWrite);
        end
        #5 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_load_use_rs();
        drive(5'd1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
        drive(5'd8, 5'd2, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);
        total++;
        if (PC_write !== 1'b0 || IF_ID_write !== 1'b0) begin
            bad++;
            $display("[TB] FAIL lu_rs_stall got pc=%b ifw=%b want 0 0", PC_write, IF_ID_write);
        end
        advance();
        drive(5'd8, 5'd2, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);
        total++;
        if (PC_write !== 1'b1 || Rs_addr !== 5'd0 || EX_Mem_Rd_addr !== 5'd8) begin
            bad++;
            $display("[TB] FAIL lu_rs_release got pc=%b rs=%0d exrd=%0d want 1 0 8",
                     PC_write, Rs_addr, EX_Mem_Rd_addr);
        end
        advance();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (EX_Mem_Rd_addr !== 5'd0 || EX_Mem_RegWrite !== 1'b0 || Rs_addr !== 5'd8) begin
            bad++;
            $display("[TB] FAIL lu_rs_bubble got exrd=%0d exrw=%b rs=%0d want 0 0 8",
                     EX_Mem_Rd_addr, EX_Mem_RegWrite, Rs_addr);
        end
        advance();
    endtask

    task automatic test_rt_gating();
        drive(5'd1, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
        drive(5'd1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (PC_write !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rt_unused got pc=%b want 1", PC_write);
        end
        advance();
        drive(5'd1, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
        drive(5'd1, 5'd9, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0);
        total++;
        if (PC_write !== 1'b0 || IF_ID_write !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rt_used got pc=%b ifw=%b want 0 0", PC_write, IF_ID_write);
        end
        advance();
        drive(5'd2, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
        drive(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        total++;
        if (PC_write !== 1'b1) begin
            bad++;
            $display("[TB] FAIL lw_zero got pc=%b want 1", PC_write);
        end
        advance();
    endtask

    task automatic test_flush_vs_stall();
        drive(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        advance();
        drive(5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
        drive(5'd7, 5'd7, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1);
        total++;
        if (IF_ID_flush !== 1'b1 || PC_write !== 1'b1 || IF_ID_write !== 1'b1 ||
            EX_Mem_Rd_addr !== 5'd5) begin
            bad++;
            $display("[TB] FAIL flush_prio got fl=%b pc=%b ifw=%b exrd=%0d want 1 1 1 5",
                     IF_ID_flush, PC_write, IF_ID_write, EX_Mem_Rd_addr);
        end
        advance();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (Rs_addr !== 5'd0 || Rt_addr !== 5'd0 || Mem_WB_Rd_addr !== 5'd5 ||
            Mem_WB_RegWrite !== 1'b1 || EX_Mem_Rd_addr !== 5'd7) begin
            bad++;
            $display("[TB] FAIL flush_retire got rs=%0d rt=%0d wbrd=%0d wbrw=%b exrd=%0d want 0 0 5 1 7",
                     Rs_addr, Rt_addr, Mem_WB_Rd_addr, Mem_WB_RegWrite, EX_Mem_Rd_addr);
        end
        advance();
    endtask

    task automatic test_propagation();
        logic [4:0] exp_wb [4];
        drive(5'd4, 5'd6, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        advance();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (Rs_addr !== 5'd4 || Rt_addr !== 5'd6) begin
            bad++;
            $display("[TB] FAIL prop_ex got rs=%0d rt=%0d want 4 6", Rs_addr, Rt_addr);
        end
        advance();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (EX_Mem_Rd_addr !== 5'd3 || EX_Mem_RegWrite !== 1'b1) begin
            bad++;
            $display("[TB] FAIL prop_mem got rd=%0d rw=%b want 3 1", EX_Mem_Rd_addr, EX_Mem_RegWrite);
        end
        advance();
        exp_wb[0] = 5'd3;
        exp_wb[1] = 5'd0;
        for (int i = 0; i < 2; i++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            total++;
            if (Mem_WB_Rd_addr !== exp_wb[i] || Mem_WB_RegWrite !== (i == 0)) begin
                bad++;
                $display("[TB] FAIL prop_wb%0d got rd=%0d rw=%b want %0d %b",
                         i, Mem_WB_Rd_addr, Mem_WB_RegWrite, exp_wb[i], (i == 0));
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [4:0] r [3];
        logic [24:0] exp_v, got_v;
        logic s;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 3; k++)
                r[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            drive(r[0], r[1], r[2], 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
            s = model_stall();
            exp_v = {br || !s, br || !s, br, pipe[0].rs, pipe[0].rt,
                     pipe[1].rd, pipe[1].rw, pipe[2].rd, pipe[2].rw};
            got_v = {PC_write, IF_ID_write, IF_ID_flush, Rs_addr, Rt_addr,
                     EX_Mem_Rd_addr, EX_Mem_RegWrite, Mem_WB_Rd_addr, Mem_WB_RegWrite};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("[TB] FAIL random_cycle%0d got %h want %h", n, got_v, exp_v);
            end
`ifdef HAZARD_STAT_CNT_EN
            total++;
            if (Stall_cnt !== model_stalls || Flush_cnt !== model_flushes) begin
                bad++;
                $display("[TB] FAIL counters got s=%0d f=%0d want %0d %0d",
                         Stall_cnt, Flush_cnt, model_stalls, model_flushes);
            end
`endif
            advance();
        end
    endtask

    task automatic test_async_reset();
        drive(5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
        @(posedge clk);
        #1;
        id_rs = 5'd8; id_rt = 5'd2; id_rd = 5'd10; id_mr = 1'b0; id_ut = 1'b1;
        #1;
        total++;
        if (PC_write !== 1'b0) begin
            bad++;
            $display("[TB] FAIL arst_pre_stall got pc=%b want 0", PC_write);
        end
        rst = 1'b1;
        #1;
        total++;
        if (PC_write !== 1'b1 || Rs_addr !== 5'd0 || Rt_addr !== 5'd0 ||
            EX_Mem_Rd_addr !== 5'd0 || EX_Mem_RegWrite !== 1'b0 ||
            Mem_WB_Rd_addr !== 5'd0 || Mem_WB_RegWrite !== 1'b0) begin
            bad++;
            $display("[TB] FAIL arst_clear got pc=%b rs=%0d rt=%0d exrd=%0d exrw=%b wbrd=%0d wbrw=%b",
                     PC_write, Rs_addr, Rt_addr, EX_Mem_Rd_addr, EX_Mem_RegWrite,
                     Mem_WB_Rd_addr, Mem_WB_RegWrite);
        end
        #1 rst = 1'b0;
        model_reset();
        drive(5'd8, 5'd2, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);
        total++;
        if (PC_write !== 1'b1 || IF_ID_write !== 1'b1) begin
            bad++;
            $display("[TB] FAIL arst_no_pending got pc=%b ifw=%b want 1 1", PC_write, IF_ID_write);
        end
        advance();
    endtask

    initial begin
        test_reset();
        test_load_use_rs();
        test_rt_gating();
        test_flush_vs_stall();
        test_propagation();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
